// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO accumulate unit: op encodings,
// accumulate latency and small op-decoding helpers.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_WR_BOTH = 3'd1,
    OP_WR_HI   = 3'd2,
    OP_WR_LO   = 3'd3,
    OP_MADD    = 3'd4,
    OP_MADDU   = 3'd5,
    OP_MSUB    = 3'd6,
    OP_MSUBU   = 3'd7
  } op_e;

  // Cycles from accepting an accumulate to its result appearing on hi_o/lo_o.
  localparam int unsigned ACC_LAT = 2;

  // All accumulate ops have the top opcode bit set.
  function automatic logic op_is_acc(input logic [2:0] op);
    return op[2];
  endfunction

  // MSUB/MSUBU subtract the product.
  function automatic logic op_is_sub(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // MADD/MSUB are signed; the U variants are unsigned.
  function automatic logic op_is_signed(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/hilo_acc_add.sv
// Combinational 2W-bit add/subtract of a product into HI:LO with optional
// signed or unsigned saturation. No state lives here.
module hilo_acc_add
  import hilo_pkg::*;
#(
  parameter int W   = 32,
  parameter bit SAT = 1'b0
) (
  input  logic [2*W-1:0] acc_i,
  input  logic [2*W-1:0] prod_i,
  input  logic           sub_i,
  input  logic           signed_i,
  output logic [2*W-1:0] res_o,
  output logic           sat_o
);

  localparam int W2 = 2 * W;
  localparam logic [W2-1:0] SMAX = {1'b0, {(W2-1){1'b1}}};
  localparam logic [W2-1:0] SMIN = {1'b1, {(W2-1){1'b0}}};
  localparam logic [W2-1:0] UMAX = {W2{1'b1}};
  localparam logic [W2-1:0] ZERO = {W2{1'b0}};

  logic [W2:0]   ext_s;
  logic [W2-1:0] raw_s;
  logic          ovf_s;

  // Raw sum/difference with a carry/borrow bit, plus overflow detection.
  always_comb begin
    ext_s = {1'b0, acc_i} + {1'b0, prod_i};
    if (sub_i) begin
      ext_s = {1'b0, acc_i} - {1'b0, prod_i};
    end else begin
      ext_s = {1'b0, acc_i} + {1'b0, prod_i};
    end
    raw_s = ext_s[W2-1:0];
    ovf_s = 1'b0;
    if (signed_i) begin
      // Signed overflow: operands (after negation for subtract) share a sign
      // that the result does not.
      if (sub_i) begin
        ovf_s = (acc_i[W2-1] != prod_i[W2-1]) && (raw_s[W2-1] != acc_i[W2-1]);
      end else begin
        ovf_s = (acc_i[W2-1] == prod_i[W2-1]) && (raw_s[W2-1] != acc_i[W2-1]);
      end
    end else begin
      // Unsigned: carry out on add, borrow out on subtract.
      ovf_s = ext_s[W2];
    end
  end

  // Clamp on overflow when saturation is built in, otherwise wrap.
  always_comb begin
    res_o = raw_s;
    sat_o = 1'b0;
    if (SAT && ovf_s) begin
      sat_o = 1'b1;
      if (signed_i) begin
        // A signed overflow always pushes away from the accumulator's sign.
        res_o = acc_i[W2-1] ? SMIN : SMAX;
      end else begin
        res_o = sub_i ? ZERO : UMAX;
      end
    end else begin
      res_o = raw_s;
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/hilo_acc_unit.sv
// HI/LO register pair with single-cycle plain writes and a two-stage
// multiply-accumulate path (product in, {HI,LO} +/- product out).
module hilo_acc_unit
  import hilo_pkg::*;
#(
  parameter int W   = 32,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  input  logic [2:0]   op,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic         flush,
  output logic         op_ready,
  output logic         busy,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] hi_fwd,
  output logic [W-1:0] lo_fwd,
  output logic         sat_o
);

  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           sat_q, sat_d;
  logic           busy_q, busy_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic           sub_q, sub_d;
  logic           sgn_q, sgn_d;

  logic           op_ready_s;
  logic           accept_s;
  logic [W-1:0]   hi_fwd_s;
  logic [W-1:0]   lo_fwd_s;
  logic [2*W-1:0] acc_res_s;
  logic           acc_sat_s;

  hilo_acc_add #(
    .W   (W),
    .SAT (SAT)
  ) u_add (
    .acc_i    ({hi_q, lo_q}),
    .prod_i   (prod_q),
    .sub_i    (sub_q),
    .signed_i (sgn_q),
    .res_o    (acc_res_s),
    .sat_o    (acc_sat_s)
  );

  // Handshake: a pending accumulate or a flush blocks new ops.
  always_comb begin
    op_ready_s = !busy_q && !flush;
    accept_s   = op_valid && op_ready_s;
  end

  // Forwarded view: this cycle's accepted plain write, else the registers.
  always_comb begin
    hi_fwd_s = hi_q;
    lo_fwd_s = lo_q;
    if (accept_s) begin
      case (op)
        OP_WR_BOTH: begin
          hi_fwd_s = hi_i;
          lo_fwd_s = lo_i;
        end
        OP_WR_HI: hi_fwd_s = hi_i;
        OP_WR_LO: lo_fwd_s = lo_i;
        default: begin
          hi_fwd_s = hi_q;
          lo_fwd_s = lo_q;
        end
      endcase
    end else begin
      hi_fwd_s = hi_q;
      lo_fwd_s = lo_q;
    end
  end

  // Next state: stage-2 writeback, flush discard, or stage-1 launch.
  always_comb begin
    hi_d   = hi_fwd_s;
    lo_d   = lo_fwd_s;
    sat_d  = sat_q;
    busy_d = 1'b0;
    prod_d = prod_q;
    sub_d  = sub_q;
    sgn_d  = sgn_q;
    if (busy_q) begin
      if (flush) begin
        // Drop the in-flight result; busy falls at this edge.
        hi_d = hi_q;
        lo_d = lo_q;
      end else begin
        {hi_d, lo_d} = acc_res_s;
        sat_d        = sat_q | acc_sat_s;
      end
    end else if (accept_s && op_is_acc(op)) begin
      busy_d = 1'b1;
      prod_d = {hi_i, lo_i};
      sub_d  = op_is_sub(op);
      sgn_d  = op_is_signed(op);
    end else if (accept_s && (op == OP_WR_BOTH)) begin
      sat_d = 1'b0;
    end else begin
      sat_d = sat_q;
    end
  end

  // State registers with synchronous reset that overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      sat_q  <= 1'b0;
      busy_q <= 1'b0;
      prod_q <= '0;
      sub_q  <= 1'b0;
      sgn_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      sat_q  <= sat_d;
      busy_q <= busy_d;
      prod_q <= prod_d;
      sub_q  <= sub_d;
      sgn_q  <= sgn_d;
    end
  end

  assign op_ready = op_ready_s;
  assign busy     = busy_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign hi_fwd   = hi_fwd_s;
  assign lo_fwd   = lo_fwd_s;
  assign sat_o    = sat_q;

endmodule
